// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - opcodes, exception codes, FSM states and stack ops for the RPN engine
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_NEG  = 3'd4,
    OP_DUP  = 3'd5,
    OP_SWAP = 3'd6,
    OP_EQ   = 3'd7
  } op_e;

  localparam logic [2:0] EXC_NONE      = 3'd0;
  localparam logic [2:0] EXC_STK_OVF   = 3'd1;
  localparam logic [2:0] EXC_STK_UNF   = 3'd2;
  localparam logic [2:0] EXC_ARITH     = 3'd3;
  localparam logic [2:0] EXC_MALFORMED = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_EMIT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SOP_NONE     = 3'd0,
    SOP_PUSH     = 3'd1,
    SOP_POP1     = 3'd2,
    SOP_POP2PUSH = 3'd3,
    SOP_REPL     = 3'd4,
    SOP_SWAP     = 3'd5,
    SOP_CLEAR    = 3'd6
  } stk_op_e;

endpackage

// File: rtl/rpn_stack.sv
// rtl/rpn_stack.sv - register-file LIFO with entry 0 always holding the top of stack
module rpn_stack
  import rpn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  stk_op_e                      op,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            top,
  output logic [DATA_W-1:0]            second,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     cnt;

  assign top    = mem[0];
  assign second = mem[1];
  assign depth  = cnt;

  // Pushes shift the file down, pops shift it up; slots past the count are kept zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (op)
        SOP_PUSH: begin
          mem[0] <= din;
          for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
          cnt <= cnt + 1'b1;
        end
        SOP_POP1: begin
          for (int i = 0; i < DEPTH-1; i++) mem[i] <= mem[i+1];
          mem[DEPTH-1] <= '0;
          cnt <= cnt - 1'b1;
        end
        SOP_POP2PUSH: begin
          mem[0] <= din;
          for (int i = 1; i < DEPTH-1; i++) mem[i] <= mem[i+1];
          mem[DEPTH-1] <= '0;
          cnt <= cnt - 1'b1;
        end
        SOP_REPL: mem[0] <= din;
        SOP_SWAP: begin
          mem[0] <= mem[1];
          mem[1] <= mem[0];
        end
        SOP_CLEAR: begin
          cnt <= '0;
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rpn_stack_engine.sv
// rtl/rpn_stack_engine.sv - postfix token evaluator: FSM, signed ALU and coded exceptions
module rpn_stack_engine
  import rpn_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter bit OVF_TRAP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tok_valid,
  output logic                         tok_ready,
  input  logic [2:0]                   tok_op,
  input  logic [DATA_W-1:0]            tok_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [DATA_W-1:0]            res_data,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         exc,
  output logic [2:0]                   exc_code
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);
  localparam logic [CW-1:0]     TWO  = CW'(2);
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_e            state, state_n;
  op_e               op_q;
  logic [DATA_W-1:0] data_q;
  stk_op_e           stk_op;
  logic [DATA_W-1:0] stk_din, top, second;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic [2*DATA_W-1:0] prod;
  logic              fault_set, fault_clr;
  logic [2:0]        fault_code;

  rpn_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_stack (
    .clk    (clk),
    .rst    (rst),
    .op     (stk_op),
    .din    (stk_din),
    .top    (top),
    .second (second),
    .depth  (depth)
  );

  assign res_data = (state == ST_EMIT) ? top : '0;

  // Signed S-op-T arithmetic with two's-complement overflow detection; results always wrap.
  always_comb begin
    prod    = {{DATA_W{second[DATA_W-1]}}, second} * {{DATA_W{top[DATA_W-1]}}, top};
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = second + top;
        alu_ovf = (second[DATA_W-1] == top[DATA_W-1]) && (alu_res[DATA_W-1] != second[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = second - top;
        alu_ovf = (second[DATA_W-1] != top[DATA_W-1]) && (alu_res[DATA_W-1] != second[DATA_W-1]);
      end
      OP_MUL: begin
        alu_res = prod[DATA_W-1:0];
        alu_ovf = !((&prod[2*DATA_W-1:DATA_W-1]) || !(|prod[2*DATA_W-1:DATA_W-1]));
      end
      OP_NEG: begin
        alu_res = '0 - top;
        alu_ovf = (top == SMIN);
      end
      default: ;
    endcase
  end

  // Next state, handshakes and stack command; a failing op issues no stack command at all.
  always_comb begin
    state_n    = state;
    tok_ready  = 1'b0;
    res_valid  = 1'b0;
    stk_op     = SOP_NONE;
    stk_din    = '0;
    fault_set  = 1'b0;
    fault_clr  = 1'b0;
    fault_code = EXC_NONE;
    case (state)
      ST_IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid) state_n = ST_EXEC;
      end
      ST_EXEC: begin
        state_n = ST_IDLE;
        case (op_q)
          OP_PUSH: begin
            if (depth == FULL) begin
              fault_set = 1'b1; fault_code = EXC_STK_OVF;
            end else begin
              stk_op = SOP_PUSH; stk_din = data_q;
            end
          end
          OP_ADD, OP_SUB, OP_MUL: begin
            if (depth < TWO) begin
              fault_set = 1'b1; fault_code = EXC_STK_UNF;
            end else if (alu_ovf && OVF_TRAP) begin
              fault_set = 1'b1; fault_code = EXC_ARITH;
            end else begin
              stk_op = SOP_POP2PUSH; stk_din = alu_res;
            end
          end
          OP_NEG: begin
            if (depth == '0) begin
              fault_set = 1'b1; fault_code = EXC_STK_UNF;
            end else if (alu_ovf && OVF_TRAP) begin
              fault_set = 1'b1; fault_code = EXC_ARITH;
            end else begin
              stk_op = SOP_REPL; stk_din = alu_res;
            end
          end
          OP_DUP: begin
            if (depth == '0) begin
              fault_set = 1'b1; fault_code = EXC_STK_UNF;
            end else if (depth == FULL) begin
              fault_set = 1'b1; fault_code = EXC_STK_OVF;
            end else begin
              stk_op = SOP_PUSH; stk_din = top;
            end
          end
          OP_SWAP: begin
            if (depth < TWO) begin
              fault_set = 1'b1; fault_code = EXC_STK_UNF;
            end else begin
              stk_op = SOP_SWAP;
            end
          end
          OP_EQ: begin
            if (depth == CW'(1)) state_n = ST_EMIT;
            else begin
              fault_set = 1'b1; fault_code = EXC_MALFORMED;
            end
          end
          default: ;
        endcase
        if (fault_set) state_n = ST_FAULT;
      end
      ST_EMIT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          stk_op  = SOP_CLEAR;
          state_n = ST_IDLE;
        end
      end
      ST_FAULT: begin
        tok_ready = 1'b1;
        if (tok_valid && tok_op == OP_EQ) begin
          fault_clr = 1'b1;
          stk_op    = SOP_CLEAR;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (rst) begin
      tok_ready = 1'b0;
      res_valid = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Token latch on the IDLE handshake and the sticky exception flag/code.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_PUSH;
      data_q   <= '0;
      exc      <= 1'b0;
      exc_code <= EXC_NONE;
    end else begin
      if (state == ST_IDLE && tok_valid) begin
        op_q   <= op_e'(tok_op);
        data_q <= tok_data;
      end
      if (fault_set) begin
        exc      <= 1'b1;
        exc_code <= fault_code;
      end else if (fault_clr) begin
        exc      <= 1'b0;
        exc_code <= EXC_NONE;
      end
    end
  end

endmodule

// File: tb/tb_rpn_stack_engine.sv
// tb/tb_rpn_stack_engine.sv - scoreboard bench for rpn_stack_engine (trapping and wrapping builds)
module tb_rpn_stack_engine;
  import rpn_pkg::*;

  typedef struct {
    int d;
    int e;
    int c;
  } st_t;

  logic       clk, rst, sel;
  logic       tok_valid, res_ready;
  logic [2:0] tok_op;
  logic [7:0] tok_data;

  logic       m_tok_ready, m_res_valid, m_exc;
  logic [7:0] m_res_data;
  logic [3:0] m_depth;
  logic [2:0] m_code;
  logic       w_tok_ready, w_res_valid, w_exc;
  logic [7:0] w_res_data;
  logic [3:0] w_depth;
  logic [2:0] w_code;

  logic       s_tok_ready, s_res_valid, s_exc;
  logic [7:0] s_res_data;
  logic [3:0] s_depth;
  logic [2:0] s_code;

  int   checks = 0;
  int   errors = 0;
  st_t  exp_st[$];
  int   exp_res[$];

  rpn_stack_engine #(.DATA_W(8), .DEPTH(8), .OVF_TRAP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid && !sel), .tok_ready(m_tok_ready),
    .tok_op(tok_op), .tok_data(tok_data), .res_valid(m_res_valid), .res_ready(res_ready),
    .res_data(m_res_data), .depth(m_depth), .exc(m_exc), .exc_code(m_code)
  );

  rpn_stack_engine #(.DATA_W(8), .DEPTH(8), .OVF_TRAP(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .tok_valid(tok_valid && sel), .tok_ready(w_tok_ready),
    .tok_op(tok_op), .tok_data(tok_data), .res_valid(w_res_valid), .res_ready(res_ready),
    .res_data(w_res_data), .depth(w_depth), .exc(w_exc), .exc_code(w_code)
  );

  assign s_tok_ready = sel ? w_tok_ready : m_tok_ready;
  assign s_res_valid = sel ? w_res_valid : m_res_valid;
  assign s_res_data  = sel ? w_res_data  : m_res_data;
  assign s_depth     = sel ? w_depth     : m_depth;
  assign s_exc       = sel ? w_exc       : m_exc;
  assign s_code      = sel ? w_code      : m_code;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one token, record its expected status (and result), then leave the line idle.
  task automatic send(input logic [2:0] op, input int data, input int ed, input int ee,
                      input int ec, input bit has_res = 1'b0, input int rv = 0);
    bit taken;
    st_t s;
    taken     = 1'b0;
    tok_valid = 1'b1;
    tok_op    = op;
    tok_data  = data[7:0];
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_tok_ready) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) begin
      chk("tok_accept_timeout", 0, 1);
      tok_valid = 1'b0;
      return;
    end
    s.d = ed; s.e = ee; s.c = ec;
    exp_st.push_back(s);
    if (has_res) exp_res.push_back(rv);
    @(posedge clk); #1;
    tok_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Status monitor: two cycles after each accepted token, compare occupancy and exception.
  initial forever begin
    @(negedge clk);
    if (!rst && tok_valid && s_tok_ready) begin
      @(negedge clk);
      @(negedge clk);
      if (exp_st.size() == 0) chk("status_unexpected", 1, 0);
      else begin
        st_t e;
        e = exp_st.pop_front();
        chk("depth", s_depth, e.d);
        chk("exc", s_exc, e.e);
        chk("exc_code", s_code, e.c);
      end
    end
  end

  // Result monitor: every result handshake must match the next expected result.
  initial forever begin
    @(negedge clk);
    if (!rst && s_res_valid && res_ready) begin
      if (exp_res.size() == 0) chk("result_unexpected", s_res_data, 32'hdead);
      else chk("res_data", s_res_data, exp_res.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sel = 1'b0; tok_valid = 1'b0; tok_op = 3'd0; tok_data = 8'd0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tok_ready", m_tok_ready, 0);
    chk("rst_res_valid", m_res_valid, 0);
    chk("rst_res_data", m_res_data, 0);
    chk("rst_depth", m_depth, 0);
    chk("rst_exc", m_exc, 0);
    chk("rst_exc_code", m_code, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // (5+23)*2-12 = 44
    send(OP_PUSH, 5, 1, 0, 0);
    send(OP_PUSH, 23, 2, 0, 0);
    send(OP_ADD, 0, 1, 0, 0);
    send(OP_DUP, 0, 2, 0, 0);
    send(OP_ADD, 0, 1, 0, 0);
    send(OP_PUSH, 12, 2, 0, 0);
    send(OP_SUB, 0, 1, 0, 0);
    send(OP_EQ, 0, 1, 0, 0, 1'b1, 'h2C);

    // mixed ops: (-3*7) then 5 SWAP SUB NEG -> -(5-(-21)) = -26
    send(OP_PUSH, -3, 1, 0, 0);
    send(OP_PUSH, 7, 2, 0, 0);
    send(OP_MUL, 0, 1, 0, 0);
    send(OP_PUSH, 5, 2, 0, 0);
    send(OP_SWAP, 0, 2, 0, 0);
    send(OP_SUB, 0, 1, 0, 0);
    send(OP_NEG, 0, 1, 0, 0);
    send(OP_EQ, 0, 1, 0, 0, 1'b1, 'hE6);

    // stack overflow on the ninth push, then EQ clears without a result
    for (int i = 1; i <= 8; i++) send(OP_PUSH, 1, i, 0, 0);
    send(OP_PUSH, 1, 8, 1, 1);
    send(OP_EQ, 0, 0, 0, 0);

    // underflow, tokens discarded while faulted, malformed EQ
    send(OP_ADD, 0, 0, 1, 2);
    send(OP_PUSH, 9, 0, 1, 2);
    send(OP_EQ, 0, 0, 0, 0);
    send(OP_PUSH, 3, 1, 0, 0);
    send(OP_PUSH, 4, 2, 0, 0);
    send(OP_EQ, 0, 2, 1, 4);
    send(OP_EQ, 0, 0, 0, 0);
    send(OP_EQ, 0, 0, 1, 4);
    send(OP_EQ, 0, 0, 0, 0);
    send(OP_PUSH, 1, 1, 0, 0);
    send(OP_SWAP, 0, 1, 1, 2);
    send(OP_EQ, 0, 0, 0, 0);

    // arithmetic overflow traps leave the operands in place
    send(OP_PUSH, 100, 1, 0, 0);
    send(OP_PUSH, 100, 2, 0, 0);
    send(OP_ADD, 0, 2, 1, 3);
    send(OP_EQ, 0, 0, 0, 0);
    send(OP_PUSH, -128, 1, 0, 0);
    send(OP_NEG, 0, 1, 1, 3);
    send(OP_EQ, 0, 0, 0, 0);
    send(OP_PUSH, 16, 1, 0, 0);
    send(OP_PUSH, 8, 2, 0, 0);
    send(OP_MUL, 0, 2, 1, 3);
    send(OP_EQ, 0, 0, 0, 0);

    // backpressure on the result
    res_ready = 1'b0;
    send(OP_PUSH, 7, 1, 0, 0);
    send(OP_EQ, 0, 1, 0, 0, 1'b1, 7);
    repeat (5) begin
      @(negedge clk);
      chk("bp_res_valid", m_res_valid, 1);
      chk("bp_res_data", m_res_data, 7);
      chk("bp_tok_ready", m_tok_ready, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_res_valid", m_res_valid, 0);
    chk("bp_after_depth", m_depth, 0);
    chk("bp_after_tok_ready", m_tok_ready, 1);
    @(posedge clk); #1;

    // reset while a result is pending
    res_ready = 1'b0;
    send(OP_PUSH, 9, 1, 0, 0);
    send(OP_EQ, 0, 1, 0, 0);
    @(negedge clk);
    chk("emit_before_rst", m_res_valid, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_emit_res_valid", m_res_valid, 0);
    chk("rst_emit_depth", m_depth, 0);
    chk("rst_emit_tok_ready", m_tok_ready, 1);
    @(posedge clk); #1;
    res_ready = 1'b1;

    // reset while a token is executing: the push is lost
    send(OP_PUSH, 2, 1, 0, 0);
    begin
      st_t s;
      s.d = 0; s.e = 0; s.c = 0;
      exp_st.push_back(s);
      tok_valid = 1'b1; tok_op = OP_PUSH; tok_data = 8'd5;
      @(negedge clk);
      @(posedge clk); #1;
      tok_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_exec_tok_ready", m_tok_ready, 1);
      chk("rst_exec_res_valid", m_res_valid, 0);
      @(posedge clk); #1;
    end

    // reset while faulted clears the exception
    send(OP_ADD, 0, 0, 1, 2);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_fault_exc", m_exc, 0);
    chk("rst_fault_code", m_code, 0);
    chk("rst_fault_tok_ready", m_tok_ready, 1);
    @(posedge clk); #1;

    // wrapping build: overflow writes the wrapped value
    sel = 1'b1;
    send(OP_PUSH, 100, 1, 0, 0);
    send(OP_PUSH, 100, 2, 0, 0);
    send(OP_ADD, 0, 1, 0, 0);
    send(OP_EQ, 0, 1, 0, 0, 1'b1, 'hC8);
    send(OP_PUSH, -128, 1, 0, 0);
    send(OP_NEG, 0, 1, 0, 0);
    send(OP_EQ, 0, 1, 0, 0, 1'b1, 'h80);
    sel = 1'b0;

    repeat (5) @(negedge clk);
    chk("status_queue_drained", exp_st.size(), 0);
    chk("result_queue_drained", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpn_stack_engine.md
Name: rpn_stack_engine

Overview:
Parametrised stack-machine evaluator, successor to the fixed-program calculator. Consumes a stream of postfix tokens (push-constant or operator) over a valid/ready handshake and executes each on an internal LIFO of configurable width and depth. On an EQ token it emits the single remaining stack value over a result handshake. Stack overflow, stack underflow, signed arithmetic overflow and malformed expressions raise a coded exception instead of a bare flag. Sits between the token source (front-end/host) and the result consumer.

Parameters:
DATA_W, 8, operand/result width, signed two's complement
DEPTH, 8, stack entries (>=2)
OVF_TRAP, 1, 1: signed arithmetic overflow faults; 0: wraps silently

Ports:
clk  in  1  clock, all state rises on posedge
rst  in  1  reset, synchronous, active-high
tok_valid  in  1  token present
tok_ready  out  1  engine accepts token this cycle
tok_op  in  3  opcode: 0 PUSH, 1 ADD, 2 SUB, 3 MUL, 4 NEG, 5 DUP, 6 SWAP, 7 EQ
tok_data  in  DATA_W  constant for PUSH, ignored otherwise
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_data  out  DATA_W  result value
depth  out  $clog2(DEPTH+1)  current stack occupancy
exc  out  1  sticky fault flag
exc_code  out  3  0 none, 1 stack overflow, 2 stack underflow, 3 arith overflow, 4 malformed EQ

Behaviour:
- Reset (rst=1 at posedge): state IDLE, depth=0, tok_ready=0 in reset cycle, res_valid=0, res_data=0, exc=0, exc_code=0. Reset mid-operation discards the token in flight and any pending result.
- FSM states: IDLE, EXEC, EMIT, FAULT.
- IDLE: tok_ready=1. Handshake (tok_valid&tok_ready) latches op/data -> EXEC.
- EXEC: tok_ready=0. Applies the op in one cycle, then -> IDLE, -> EMIT (EQ, depth==1) or -> FAULT. Throughput is one token per 2 cycles.
- Op semantics (T=top, S=second):
  - PUSH: push data; needs depth<DEPTH.
  - ADD/SUB/MUL: pop T,S; push S op T; need depth>=2. SUB is S-T. MUL keeps the low DATA_W bits of the 2*DATA_W signed product.
  - NEG: T=-T; needs depth>=1.
  - DUP: push T; needs 1<=depth<DEPTH.
  - SWAP: exchange T,S; needs depth>=2.
  - EQ: needs depth==1.
- Arith overflow: ADD/SUB sign rule; MUL when the product is outside the signed DATA_W range; NEG of the minimum value. If OVF_TRAP=1 -> FAULT with code 3. If OVF_TRAP=0 -> wrapped result written, no fault.
- Precondition failure -> FAULT. The stack is left unchanged (a failed op has no partial pop/push). Code 1 = push would exceed DEPTH. Code 2 = too few operands. Code 4 = EQ with depth!=1 (includes empty).
- EMIT: res_valid=1 and res_data=T, held stable until res_ready. On the handshake: res_valid=0, depth=0, -> IDLE. tok_ready=0 in EMIT.
- FAULT: exc=1 and exc_code held. tok_ready=1. Every token is consumed and discarded except EQ, which clears the stack, exc and exc_code and returns to IDLE without emitting a result.
- exc_code changes only on FAULT entry or clear. Within a cycle, rst takes priority over all other events.

Decomposition:
- Package rpn_pkg holds:
  - opcode localparams/enum
  - exc_code constants
  - FSM state enum
- One sub-module, rpn_stack: register-file LIFO, parametrised DATA_W/DEPTH.
  - Outputs: top, second, depth.
  - Ops: push, pop1, pop2push (replace two with one), replace-top, swap, clear. One op per cycle.
- Engine holds the FSM, ALU and overflow detection.

Test Plan:
- Nominal (in+23)*2-12, in=5, DATA_W=8: PUSH 5, PUSH 23, ADD, DUP, ADD, PUSH 12, SUB, EQ -> res_valid with res_data=44 (0x2C); depth 0 after the handshake; exc=0.
- Overflow: DEPTH=8, 9 PUSHes of 1 -> 9th raises exc=1, code 1, depth stays 8. EQ then clears: depth=0, exc=0, no res_valid.
- Underflow/malformed: ADD on an empty stack -> code 2, depth 0. After clearing, PUSH 3, PUSH 4, EQ -> code 4.
- Arith overflow: PUSH 100, PUSH 100, ADD. OVF_TRAP=1 -> code 3, stack still holds 100,100. OVF_TRAP=0 -> T=0xC8 (-56), no fault. Also PUSH -128, NEG with OVF_TRAP=1 -> code 3.
- Backpressure: PUSH 7, EQ, res_ready low 5 cycles -> res_valid=1 and res_data=7 stable, tok_ready=0 throughout; res_ready=1 -> result taken next edge, then IDLE.
- Reset mid-operation: assert rst during EMIT and during EXEC -> next cycle res_valid=0, depth=0, exc=0, state IDLE, the in-flight token is lost.
